// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the memory-access sequencer: opcodes,
// EAB offset-select encodings and the sequencer state type.
package lc3_pkg;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;

  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_IND,
    S_IMAR,
    S_ACC,
    S_FIN
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LD, OP_LDI, OP_LDR, OP_LEA, OP_ST, OP_STI, OP_STR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// Clearable, saturating 8-bit memory-wait counter; timeout_o flags when
// the count has reached WAIT_MAX.
module lc3_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/lc3_mem_seq.sv
// Multi-cycle sequencer for LC-3 LD/LDI/LDR/LEA/ST/STI/STR: drives EAB
// selects, MAR/MDR/regfile strobes and handshakes with memory.
module lc3_mem_seq
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] IR,
  input  logic        memRdy,
  output logic [15:0] irQ,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        ldMAR,
  output logic        selMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memEN,
  output logic        memWE,
  output logic        ldReg,
  output logic        selReg,
  output logic        ldCC,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic [15:0] irq_q, irq_d;
  logic        illegal_q, illegal_d;
  logic        waiting, timer_hit, timeout;

  logic [3:0] op;
  logic       is_load, is_store, is_ind, is_base;

  assign op       = irq_q[15:12];
  assign is_load  = (op == OP_LD) || (op == OP_LDI) || (op == OP_LDR);
  assign is_store = (op == OP_ST) || (op == OP_STI) || (op == OP_STR);
  assign is_ind   = (op == OP_LDI) || (op == OP_STI);
  assign is_base  = (op == OP_LDR) || (op == OP_STR);

  // Counter runs only while a memory request is outstanding; any other
  // state holds it cleared, so each IND/ACC entry starts from zero.
  assign waiting = (state_q == S_IND) || (state_q == S_ACC);
  assign timeout = waiting && timer_hit && !memRdy;

  lc3_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (!waiting),
    .inc_i     (waiting && !memRdy),
    .timeout_o (timer_hit)
  );

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    illegal_d = 1'b0;
    selEAB1   = 1'b0;
    selEAB2   = EAB2_ZERO;
    ldMAR     = 1'b0;
    selMAR    = 1'b0;
    ldMDR     = 1'b0;
    selMDR    = 1'b0;
    memEN     = 1'b0;
    memWE     = 1'b0;
    ldReg     = 1'b0;
    selReg    = 1'b0;
    ldCC      = 1'b0;
    done      = 1'b0;
    err       = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          irq_d = IR;
          if (op_legal(IR[15:12])) state_d = S_ADDR;
          else                     illegal_d = 1'b1;
        end
      end
      S_ADDR: begin
        selEAB1 = is_base;
        selEAB2 = is_base ? EAB2_OFF6 : EAB2_OFF9;
        if (op == OP_LEA) begin
          ldReg   = 1'b1;
          selReg  = 1'b1;
          ldCC    = 1'b1;
          state_d = S_FIN;
        end else begin
          ldMAR  = 1'b1;
          ldMDR  = is_store;
          selMDR = is_store;
          state_d = is_ind ? S_IND : S_ACC;
        end
      end
      S_IND: begin
        memEN = 1'b1;
        if (memRdy) begin
          ldMDR   = 1'b1;
          state_d = S_IMAR;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_IMAR: begin
        ldMAR   = 1'b1;
        selMAR  = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        memEN = 1'b1;
        memWE = is_store;
        if (memRdy) begin
          ldMDR   = !is_store;
          state_d = S_FIN;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        ldReg   = is_load;
        ldCC    = is_load;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      illegal_q <= illegal_d;
    end
  end

  assign irQ  = irq_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: doc/lc3_mem_seq.md
# lc3_mem_seq

Multi-cycle sequencer for LC-3 address-generating instructions (LD, LDI, LDR, LEA, ST, STI, STR). Latches the instruction, drives the EAB mux selects and the MAR/MDR/memory/register-file strobes, and handshakes with memory until the access completes. Sits between the top-level control FSM, which issues `start`, and the datapath (EAB, MAR, MDR, regfile, memory port).

## Interface
- `WAIT_MAX`, 15, max cycles a memory access waits for `memRdy` before aborting; range 1..255.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin sequence; sampled only in IDLE.
- `IR`  in  16  instruction; captured on accepted `start`.
- `memRdy`  in  1  memory ack for the current read/write.
- `irQ`  out  16  latched instruction; feeds EAB `IR[10:0]` and regfile selects.
- `selEAB1`  out  1  0 = PC, 1 = base register.
- `selEAB2`  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11.
- `ldMAR`  out  1  load MAR.
- `selMAR`  out  1  0 = EAB output, 1 = MDR.
- `ldMDR`  out  1  load MDR.
- `selMDR`  out  1  0 = memory data, 1 = source register.
- `memEN`, `memWE`  out  1 each  memory request / write qualifier.
- `ldReg`, `selReg`, `ldCC`  out  1 each  regfile write; 0 = MDR, 1 = EAB; condition-code load.
- `busy`, `done`, `err`  out  1 each  sequence active; 1-cycle completion pulse; 1-cycle abort pulse.

## Operation
- States: IDLE, ADDR, IND, IMAR, ACC, FIN.
- IDLE: `start`=1 → latch IR into `irQ`, go ADDR. Illegal opcode (not 0010/1010/0110/1110/0011/1011/0111) → `err` pulse next cycle, stay IDLE.
- ADDR: `selEAB1`=1 and `selEAB2`=01 for LDR/STR; `selEAB1`=0 and `selEAB2`=10 otherwise. LEA: `ldReg`=1, `selReg`=1, `ldCC`=1, → FIN. Other opcodes: `ldMAR`=1, `selMAR`=0. ST/STR/STI: `ldMDR`=1, `selMDR`=1. LDI/STI → IND; others → ACC.
- IND: `memEN`=1, `memWE`=0; on `memRdy`: `ldMDR`=1, `selMDR`=0, → IMAR.
- IMAR: `ldMAR`=1, `selMAR`=1, → ACC.
- ACC: `memEN`=1; `memWE`=1 for stores. Loads on `memRdy`: `ldMDR`=1, `selMDR`=0. On `memRdy` → FIN.
- FIN: `done`=1. Loads: `ldReg`=1, `selReg`=0, `ldCC`=1. → IDLE.
- `ldMDR` in IND/ACC is Mealy (`memEN & memRdy & ~memWE`). All other outputs are Moore, decoded from state and `irQ`. Every strobe not listed for a state is 0; `selEAB*` are 0 outside ADDR.
- Wait counter (8 bit) clears on entry to IND/ACC and increments each cycle without `memRdy`. Count == `WAIT_MAX` without `memRdy` → `err`=1 that cycle, `memEN` drops next cycle, → IDLE with no `ldReg`.
- `busy` = state ≠ IDLE. `start` while busy is ignored, not queued.

## Timing
- Reset: state IDLE, `irQ`=0, counter 0, every output 0.
- `rst` mid-sequence aborts at the next edge with no `done` or `err`. An in-flight memory request is dropped.
- Accepted `start` at edge 0 (`memRdy` tied high): LEA `done` at cycle 2; LD/LDR/ST/STR at cycle 3; LDI/STI at cycle 5. Each memory wait cycle adds 1.
- `memRdy` on the same cycle as counter == `WAIT_MAX`: the ack wins, no `err`.
- `memRdy` outside IND/ACC is ignored.

## Structure
- Shared package `lc3_pkg`: opcode constants, `selEAB2` encoding constants, state enum.
- One natural sub-module, `lc3_wait_timer`: the clearable saturating wait counter with a timeout flag. Decode stays inline.

## Test plan
- LD, IR=16'h2405 (offset 5), `memRdy`=1: ADDR drives `selEAB1`=0, `selEAB2`=10, `ldMAR`=1. ACC has `memEN`=1, `memWE`=0, `ldMDR`=1. FIN has `ldReg`=1, `selReg`=0, `done`=1 at cycle 3.
- STR, IR=16'h7A3F, `memRdy` delayed 4 cycles: ADDR has `selEAB2`=01, `selEAB1`=1, `ldMDR`=1, `selMDR`=1. ACC holds `memEN`=`memWE`=1 for 5 cycles. `done` at cycle 7, `ldReg` never asserted.
- LDI, IR=16'hA1FF: IND read, then IMAR `selMAR`=1 `ldMAR`=1, second read, `done` at cycle 5 with `ldReg`=1.
- LEA, IR=16'hE0FE: `ldReg`=1, `selReg`=1, `ldCC`=1 in ADDR with `memEN` never asserted. `done` at cycle 2.
- Timeout, `WAIT_MAX`=3, LD with `memRdy`=0: `err` pulses on the 4th ACC cycle, state returns to IDLE, no `done`, no `ldReg`.
- Illegal IR=16'h1000 → `err` pulse, `busy` stays 0. `rst` during ACC of ST → next cycle all outputs 0. `start` while busy → no effect.
